// File: rtl/seg7_rx_pkg.sv
// Purpose : shared constants for the seven-segment digit receiver (segment
//           patterns, FSM states, xorshift32 predictor step).
// Latency : n/a (package). Backpressure: n/a.
package seg7_rx_pkg;

    // Segment patterns {g,f,e,d,c,b,a}, bit0 = a, for digits 0..9.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        TRACK      = 2'd1,
        SETTLE     = 2'd2
    } rx_state_t;

    // xorshift32 shift amounts, matching the generator.
    localparam int XS_SHL_A = 13;
    localparam int XS_SHR   = 17;
    localparam int XS_SHL_B = 5;

    function automatic logic [31:0] xorshift32(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << XS_SHL_A);
        t = t ^ (t >> XS_SHR);
        t = t ^ (t << XS_SHL_B);
        return t;
    endfunction

endpackage

// File: rtl/seg7_digit_receiver_decode.sv
// Purpose : seg7_decode, maps a 7-bit segment pattern to a BCD digit + legal flag.
// Latency : combinational.  Backpressure: none.
// Ports   : i_seg pattern in; o_digit decoded value (0 when illegal); o_legal.
module seg7_decode
    import seg7_rx_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_legal
);

    always_comb begin
        o_digit = 4'd0;
        o_legal = 1'b1;
        case (i_seg)
            SEG_0:   o_digit = 4'd0;
            SEG_1:   o_digit = 4'd1;
            SEG_2:   o_digit = 4'd2;
            SEG_3:   o_digit = 4'd3;
            SEG_4:   o_digit = 4'd4;
            SEG_5:   o_digit = 4'd5;
            SEG_6:   o_digit = 4'd6;
            SEG_7:   o_digit = 4'd7;
            SEG_8:   o_digit = 4'd8;
            SEG_9:   o_digit = 4'd9;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_digit_receiver.sv
// Purpose : samples a generator's segment bus, debounces each new pattern and
//           decodes it to a digit; a period counter re-emits unchanged digits.
// Latency : digit_valid STABLE_CYCLES edges after a pattern first hits seg_in.
// Backpressure: none; every received digit is a one-cycle pulse.
// Ports   : clk, reset (sync, active-high); i_seg_in segments; i_seed_in
//           predictor seed; o_digit/o_digit_valid/o_repeat_flag received digit;
//           o_pattern_err illegal stable pattern; o_locked first digit seen;
//           o_seq_err/o_match_cnt predictor results (only with SEQ_CHECK_EN).
// Config  : `define SEQ_CHECK_EN builds the xorshift32 sequence predictor.
module seg7_digit_receiver
    import seg7_rx_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD        = 1001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] i_seg_in,
    input  logic [5:0] i_seed_in,
    output logic [3:0] o_digit,
    output logic       o_digit_valid,
    output logic       o_repeat_flag,
    output logic       o_pattern_err,
`ifdef SEQ_CHECK_EN
    output logic       o_seq_err,
    output logic [7:0] o_match_cnt,
`endif
    output logic       o_locked
);

    localparam int             PW          = $clog2(PERIOD);
    localparam logic [3:0]     STABLE_MAX  = 4'(STABLE_CYCLES);
    localparam logic [PW-1:0]  PERIOD_LAST = PW'(PERIOD - 1);

    logic [6:0]    r_seg_q, r_cand, r_acc_pat;
    logic [3:0]    r_stable_cnt;
    logic [PW-1:0] r_period_cnt;
    rx_state_t     r_state, w_state_nxt;
    logic [3:0]    r_digit;
    logic          r_digit_valid, r_repeat_flag, r_pattern_err, r_locked;

    logic          w_changed, w_reach, w_tick;
    logic [3:0]    w_stable_nxt, w_dec_digit;
    logic          w_dec_legal, w_accept, w_repeat, w_bad;

    assign w_changed    = (r_seg_q != r_cand);
    assign w_stable_nxt = w_changed ? 4'd1 :
                          (r_stable_cnt == STABLE_MAX) ? r_stable_cnt : r_stable_cnt + 4'd1;
    // One-shot: true only on the cycle the count arrives at the threshold, so an
    // illegal pattern held indefinitely raises pattern_err exactly once.
    assign w_reach      = (w_stable_nxt == STABLE_MAX) &&
                          (w_changed || (r_stable_cnt != STABLE_MAX));
    assign w_tick       = (r_period_cnt == PERIOD_LAST);

    // The candidate's next value is always r_seg_q, so decode that directly;
    // this lets the accept pulse land on the same edge the count matures.
    seg7_decode u_decode (
        .i_seg   (r_seg_q),
        .o_digit (w_dec_digit),
        .o_legal (w_dec_legal)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_repeat    = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            WAIT_FIRST: begin
                if (w_reach) begin
                    if (w_dec_legal) begin
                        w_accept    = 1'b1;
                        w_state_nxt = TRACK;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            TRACK, SETTLE: begin
                if (r_state == TRACK && r_seg_q == r_acc_pat) begin
                    w_repeat = w_tick;
                end else if (w_reach) begin
                    // Covers SETTLE and the STABLE_CYCLES=1 case where a change
                    // matures before TRACK has handed over to SETTLE.
                    if (!w_dec_legal) begin
                        w_bad       = 1'b1;
                        w_state_nxt = SETTLE;
                    end else begin
                        w_accept    = (r_seg_q != r_acc_pat);
                        w_state_nxt = TRACK;
                    end
                end else begin
                    w_state_nxt = SETTLE;
                end
            end
            default: w_state_nxt = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg_q       <= 7'd0;
            r_cand        <= 7'd0;
            r_acc_pat     <= 7'd0;
            r_stable_cnt  <= 4'd0;
            r_period_cnt  <= '0;
            r_state       <= WAIT_FIRST;
            r_digit       <= 4'd0;
            r_digit_valid <= 1'b0;
            r_repeat_flag <= 1'b0;
            r_pattern_err <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_seg_q      <= i_seg_in;
            r_stable_cnt <= w_stable_nxt;
            r_state      <= w_state_nxt;
            if (w_changed) begin
                r_cand <= r_seg_q;
            end
            // Wraps only while tracking; elsewhere it parks at PERIOD-1.
            if (w_changed || (r_state == TRACK && w_tick)) begin
                r_period_cnt <= '0;
            end else if (!w_tick) begin
                r_period_cnt <= r_period_cnt + 1'b1;
            end
            r_digit_valid <= w_accept | w_repeat;
            r_repeat_flag <= w_repeat;
            r_pattern_err <= w_bad;
            if (w_accept) begin
                r_acc_pat <= r_seg_q;
                r_digit   <= w_dec_digit;
                r_locked  <= 1'b1;
            end
        end
    end

    assign o_digit       = r_digit;
    assign o_digit_valid = r_digit_valid;
    assign o_repeat_flag = r_repeat_flag;
    assign o_pattern_err = r_pattern_err;
    assign o_locked      = r_locked;

`ifdef SEQ_CHECK_EN
    // Predictor checks the registered digit, so seq_err / match_cnt move one
    // cycle after the digit_valid pulse they judge.
    logic [31:0] r_st, w_st_nxt;
    logic        r_first_seen, r_seq_err;
    logic [7:0]  r_match_cnt;
    logic [3:0]  w_exp_digit;

    assign w_st_nxt    = xorshift32(r_st);
    assign w_exp_digit = w_st_nxt[3:0] % 4'd10;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_st         <= {26'b0, i_seed_in};
            r_first_seen <= 1'b0;
            r_seq_err    <= 1'b0;
            r_match_cnt  <= 8'd0;
        end else if (r_digit_valid) begin
            // First digit after reset is the generator's reset display.
            if (!r_first_seen) begin
                r_first_seen <= 1'b1;
            end else begin
                r_st <= w_st_nxt;
                if (r_digit != w_exp_digit) begin
                    r_seq_err <= 1'b1;
                end else if (r_match_cnt != 8'hFF) begin
                    r_match_cnt <= r_match_cnt + 8'd1;
                end
            end
        end
    end

    assign o_seq_err   = r_seq_err;
    assign o_match_cnt = r_match_cnt;
`else
    logic w_unused_seed;
    assign w_unused_seed = ^i_seed_in;
`endif

endmodule
